// File: rtl/sequential_alu_pkg.sv
// Shared opcode encodings, FSM state type and dispatch helper for the sequential ALU.
package sequential_alu_pkg;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_MUL  = 4'd2;
   localparam logic [3:0] OP_DIV  = 4'd3;
   localparam logic [3:0] OP_SHL  = 4'd4;
   localparam logic [3:0] OP_AND  = 4'd5;
   localparam logic [3:0] OP_NAND = 4'd6;
   localparam logic [3:0] OP_OR   = 4'd7;
   localparam logic [3:0] OP_NOR  = 4'd8;
   localparam logic [3:0] OP_XOR  = 4'd9;
   localparam logic [3:0] OP_XNOR = 4'd10;
   localparam logic [3:0] OP_NOT  = 4'd11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // Divide by zero resolves immediately, so only a real divide iterates.
   function automatic state_t accept_state(input logic [3:0] op, input logic b_zero);
      if (op == OP_MUL) return ST_MUL;
      if (op == OP_DIV && !b_zero) return ST_DIV;
      return ST_DONE;
   endfunction

endpackage

// File: rtl/sequential_alu_muldiv_core.sv
// Iterative datapath: shift-add multiply (LSB first) or restoring divide (MSB first), one step per clock.
module seq_muldiv_core #(
   parameter int WIDTH = 4,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_start,
   input  logic             i_is_div,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_last,
   output logic [WIDTH-1:0] o_hi_nxt,
   output logic [WIDTH-1:0] o_lo_nxt
);

   logic             r_run;
   logic             r_is_div;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_shift;
   logic [WIDTH:0]   w_diff;

   assign o_last = r_run && (r_cnt == CNT_W'(WIDTH - 1));

   // r_hi is the product accumulator / partial remainder; r_lo the multiplier / dividend-quotient.
   always_comb begin
      w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
      w_shift  = {r_hi, r_lo[WIDTH-1]};
      w_diff   = w_shift - {1'b0, r_b};
      o_hi_nxt = w_sum[WIDTH:1];
      o_lo_nxt = {w_sum[0], r_lo[WIDTH-1:1]};
      if (r_is_div) begin
         if (!w_diff[WIDTH]) begin
            o_hi_nxt = w_diff[WIDTH-1:0];
            o_lo_nxt = {r_lo[WIDTH-2:0], 1'b1};
         end else begin
            o_hi_nxt = w_shift[WIDTH-1:0];
            o_lo_nxt = {r_lo[WIDTH-2:0], 1'b0};
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_run    <= 1'b0;
         r_is_div <= 1'b0;
         r_cnt    <= '0;
      end else if (i_start) begin
         r_run    <= 1'b1;
         r_is_div <= i_is_div;
         r_cnt    <= '0;
      end else if (r_run) begin
         r_cnt <= r_cnt + CNT_W'(1);
         if (o_last) r_run <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (i_start) begin
         r_hi <= '0;
         r_lo <= i_a;
         r_b  <= i_b;
      end else if (r_run) begin
         r_hi <= o_hi_nxt;
         r_lo <= o_lo_nxt;
      end
   end

endmodule

// File: rtl/sequential_alu.sv
// Handshaked WIDTH-bit ALU: single-cycle arithmetic/logic plus iterative MUL/DIV, one op in flight.
module sequential_alu
   import sequential_alu_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       opcode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             carry_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result_hi,
   output logic [WIDTH-1:0] result_lo,
   output logic             carry_out,
   output logic             div_by_zero,
   output logic             busy
);

   typedef struct packed {
      logic [WIDTH-1:0] hi;
      logic [WIDTH-1:0] lo;
      logic             cout;
      logic             dbz;
   } res_t;

   state_t           r_state;
   state_t           w_state_nxt;
   res_t             r_res;
   res_t             w_single;
   logic             w_accept;
   logic             w_b_zero;
   logic             w_iter;
   logic             w_last;
   logic [WIDTH-1:0] w_hi_nxt;
   logic [WIDTH-1:0] w_lo_nxt;

   function automatic res_t single_op(input logic [3:0] op, input logic [WIDTH-1:0] a_i,
                                      input logic [WIDTH-1:0] b_i, input logic cin);
      res_t               r;
      logic [WIDTH:0]     v_ext;
      logic [2*WIDTH-1:0] v_shl;
      r     = '0;
      v_ext = '0;
      v_shl = '0;
      case (op)
         OP_ADD: begin
            v_ext  = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, cin};
            r.lo   = v_ext[WIDTH-1:0];
            r.cout = v_ext[WIDTH];
         end
         OP_SUB: begin
            v_ext  = {1'b0, a_i} - {1'b0, b_i} - {{WIDTH{1'b0}}, cin};
            r.lo   = v_ext[WIDTH-1:0];
            r.cout = v_ext[WIDTH];
         end
         OP_DIV: begin
            r.lo  = '1;
            r.hi  = a_i;
            r.dbz = 1'b1;
         end
         OP_SHL: begin
            // Shift counts of 2*WIDTH or more fall off the end and yield zero.
            v_shl        = {{WIDTH{1'b0}}, a_i} << b_i;
            {r.hi, r.lo} = v_shl;
         end
         OP_AND:  r.lo = a_i & b_i;
         OP_NAND: r.lo = ~(a_i & b_i);
         OP_OR:   r.lo = a_i | b_i;
         OP_NOR:  r.lo = ~(a_i | b_i);
         OP_XOR:  r.lo = a_i ^ b_i;
         OP_XNOR: r.lo = ~(a_i ^ b_i);
         OP_NOT:  r.lo = ~a_i;
         default: r = '0;
      endcase
      return r;
   endfunction

   assign w_accept = in_valid && in_ready;
   assign w_b_zero = (b == '0);
   assign w_iter   = (accept_state(opcode, w_b_zero) != ST_DONE);
   assign w_single = single_op(opcode, a, b, carry_in);

   seq_muldiv_core #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_core (
      .clk      (clk),
      .rst      (rst),
      .i_start  (w_accept && w_iter),
      .i_is_div (opcode == OP_DIV),
      .i_a      (a),
      .i_b      (b),
      .o_last   (w_last),
      .o_hi_nxt (w_hi_nxt),
      .o_lo_nxt (w_lo_nxt)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_accept) w_state_nxt = accept_state(opcode, w_b_zero);
         ST_MUL, ST_DIV: if (w_last) w_state_nxt = ST_DONE;
         ST_DONE: begin
            if (w_accept)       w_state_nxt = accept_state(opcode, w_b_zero);
            else if (out_ready) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (r_state)
         ST_IDLE: in_ready = !rst;
         ST_MUL, ST_DIV: busy = 1'b1;
         ST_DONE: begin
            out_valid = 1'b1;
            in_ready  = !rst && out_ready;
         end
         default: ;
      endcase
   end

   // Result only changes on entry to DONE, so it holds steady under back-pressure.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_res <= '0;
      end else if (w_accept && !w_iter) begin
         r_res <= w_single;
      end else if (w_last) begin
         r_res.hi   <= w_hi_nxt;
         r_res.lo   <= w_lo_nxt;
         r_res.cout <= 1'b0;
         r_res.dbz  <= 1'b0;
      end
   end

   assign result_hi   = r_res.hi;
   assign result_lo   = r_res.lo;
   assign carry_out   = r_res.cout;
   assign div_by_zero = r_res.dbz;

endmodule

// File: tb/tb_sequential_alu.sv
// Bench for sequential_alu at WIDTH 4, 8 and 32: directed table, handshake corner cases, random vs. model.
module tb_sequential_alu;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        cout;
      logic        dbz;
      int          lat;
   } res_t;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic        cin;
      res_t        exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  t_op;
   logic [31:0] t_a, t_b;
   logic        t_cin, t_ordy;
   logic [2:0]  t_iv;
   logic [2:0]  o_irdy, o_ov, o_cout, o_dbz, o_busy;
   logic [3:0]  h4, l4;
   logic [7:0]  h8, l8;
   logic [31:0] h32, l32;
   int          n_vec = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   sequential_alu #(.WIDTH(4)) u_w4 (
      .clk(clk), .rst(rst), .in_valid(t_iv[0]), .in_ready(o_irdy[0]), .opcode(t_op),
      .a(t_a[3:0]), .b(t_b[3:0]), .carry_in(t_cin), .out_valid(o_ov[0]), .out_ready(t_ordy),
      .result_hi(h4), .result_lo(l4), .carry_out(o_cout[0]), .div_by_zero(o_dbz[0]), .busy(o_busy[0]));

   sequential_alu #(.WIDTH(8)) u_w8 (
      .clk(clk), .rst(rst), .in_valid(t_iv[1]), .in_ready(o_irdy[1]), .opcode(t_op),
      .a(t_a[7:0]), .b(t_b[7:0]), .carry_in(t_cin), .out_valid(o_ov[1]), .out_ready(t_ordy),
      .result_hi(h8), .result_lo(l8), .carry_out(o_cout[1]), .div_by_zero(o_dbz[1]), .busy(o_busy[1]));

   sequential_alu #(.WIDTH(32)) u_w32 (
      .clk(clk), .rst(rst), .in_valid(t_iv[2]), .in_ready(o_irdy[2]), .opcode(t_op),
      .a(t_a), .b(t_b), .carry_in(t_cin), .out_valid(o_ov[2]), .out_ready(t_ordy),
      .result_hi(h32), .result_lo(l32), .carry_out(o_cout[2]), .div_by_zero(o_dbz[2]), .busy(o_busy[2]));

   function automatic logic [31:0] hi_of(input int k);
      case (k)
         0:       return {28'b0, h4};
         1:       return {24'b0, h8};
         default: return h32;
      endcase
   endfunction

   function automatic logic [31:0] lo_of(input int k);
      case (k)
         0:       return {28'b0, l4};
         1:       return {24'b0, l8};
         default: return l32;
      endcase
   endfunction

   function automatic int width_of(input int k);
      case (k)
         0:       return 4;
         1:       return 8;
         default: return 32;
      endcase
   endfunction

   // Reference: plain wide arithmetic on the operand values, reduced to w bits.
   function automatic res_t model(input logic [3:0] op, input logic [31:0] a_i, input logic [31:0] b_i,
                                  input logic cin, input int w);
      longint unsigned m, a, b, p;
      res_t r;
      m = (64'd1 << w) - 64'd1;
      a = {32'b0, a_i} & m;
      b = {32'b0, b_i} & m;
      p = 64'd0;
      r.hi = '0; r.lo = '0; r.cout = 1'b0; r.dbz = 1'b0; r.lat = 1;
      case (op)
         4'd0: begin p = a + b + 64'(cin); r.lo = 32'(p & m); r.cout = 1'(p >> w); end
         4'd1: begin r.lo = 32'((a - b - 64'(cin)) & m); r.cout = (a < b + 64'(cin)); end
         4'd2: begin p = a * b; r.lo = 32'(p & m); r.hi = 32'(p >> w); r.lat = w + 1; end
         4'd3: begin
            if (b == 64'd0) begin r.lo = 32'(m); r.hi = 32'(a); r.dbz = 1'b1; end
            else begin r.lo = 32'(a / b); r.hi = 32'(a % b); r.lat = w + 1; end
         end
         4'd4: if (b < longint'(2 * w)) begin
            p = a << b; r.lo = 32'(p & m); r.hi = 32'((p >> w) & m);
         end
         4'd5:  r.lo = 32'(a & b);
         4'd6:  r.lo = 32'(~(a & b) & m);
         4'd7:  r.lo = 32'(a | b);
         4'd8:  r.lo = 32'(~(a | b) & m);
         4'd9:  r.lo = 32'(a ^ b);
         4'd10: r.lo = 32'(~(a ^ b) & m);
         4'd11: r.lo = 32'(~a & m);
         default: ;
      endcase
      return r;
   endfunction

   function automatic vec_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic cin, input logic [31:0] hi, input logic [31:0] lo,
                               input logic cout, input logic dbz, input int lat);
      vec_t v;
      v.op = op; v.a = a; v.b = b; v.cin = cin;
      v.exp.hi = hi; v.exp.lo = lo; v.exp.cout = cout; v.exp.dbz = dbz; v.exp.lat = lat;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", name, got, want);
      end
   endtask

   // Called at a negedge; returns at the negedge where the result is first visible.
   task automatic run_op(input int k, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input res_t e, input string tag);
      int   n, lat, bsy;
      logic bad_rdy;
      n = 0;
      while (!o_irdy[k] && n < 200) begin @(negedge clk); n++; end
      if (!o_irdy[k]) begin
         n_vec++; n_err++;
         $display("FAIL %s: in_ready never rose (w=%0d)", tag, width_of(k));
         return;
      end
      t_op = op; t_a = a; t_b = b; t_cin = cin; t_iv[k] = 1'b1;
      @(negedge clk);
      t_iv[k] = 1'b0;
      t_a = $urandom; t_b = $urandom; t_op = 4'($urandom); t_cin = 1'($urandom);
      lat = 1; bsy = 0; bad_rdy = 1'b0;
      while (!o_ov[k] && lat < 100) begin
         if (o_busy[k]) bsy++;
         if (o_busy[k] && o_irdy[k]) bad_rdy = 1'b1;
         @(negedge clk);
         lat++;
      end
      n_vec++;
      if (hi_of(k) !== e.hi || lo_of(k) !== e.lo || o_cout[k] !== e.cout || o_dbz[k] !== e.dbz ||
          lat != e.lat || bsy != e.lat - 1 || bad_rdy || o_ov[k] !== 1'b1) begin
         n_err++;
         $display("FAIL %s w=%0d op=%0d a=%0h b=%0h cin=%0b: got hi=%0h lo=%0h cout=%0b dbz=%0b lat=%0d busy=%0d rdy_in_busy=%0b, want hi=%0h lo=%0h cout=%0b dbz=%0b lat=%0d busy=%0d",
                  tag, width_of(k), op, a, b, cin, hi_of(k), lo_of(k), o_cout[k], o_dbz[k], lat, bsy,
                  bad_rdy, e.hi, e.lo, e.cout, e.dbz, e.lat, e.lat - 1);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        tbl[$];
      logic [3:0]  op;
      logic [31:0] ra, rb;
      logic        rc;

      t_iv = '0; t_ordy = 1'b1; t_op = '0; t_a = '0; t_b = '0; t_cin = 1'b0;
      #1 rst = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         check("reset in_ready", 32'(o_irdy[k]), 32'd0);
         check("reset out_valid/busy", {30'b0, o_ov[k], o_busy[k]}, 32'd0);
         check("reset results", hi_of(k) | lo_of(k) | 32'(o_cout[k]) | 32'(o_dbz[k]), 32'd0);
      end
      rst = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 3; k++) check("in_ready after reset", 32'(o_irdy[k]), 32'd1);

      tbl.push_back(mk(4'd0,  5,  5, 1,  0, 11, 0, 0, 1));
      tbl.push_back(mk(4'd0, 10, 10, 1,  0,  5, 1, 0, 1));
      tbl.push_back(mk(4'd0, 15,  0, 1,  0,  0, 1, 0, 1));
      tbl.push_back(mk(4'd1,  3,  6, 0,  0, 13, 1, 0, 1));
      tbl.push_back(mk(4'd1,  6,  3, 1,  0,  2, 0, 0, 1));
      tbl.push_back(mk(4'd1,  0,  0, 1,  0, 15, 1, 0, 1));
      tbl.push_back(mk(4'd2, 15, 15, 0, 14,  1, 0, 0, 5));
      tbl.push_back(mk(4'd2,  0,  9, 0,  0,  0, 0, 0, 5));
      tbl.push_back(mk(4'd3, 13,  3, 0,  1,  4, 0, 0, 5));
      tbl.push_back(mk(4'd3,  3,  7, 0,  3,  0, 0, 0, 5));
      tbl.push_back(mk(4'd3,  5,  0, 0,  5, 15, 0, 1, 1));
      tbl.push_back(mk(4'd4, 11,  2, 0,  2, 12, 0, 0, 1));
      tbl.push_back(mk(4'd4, 15,  7, 0,  8,  0, 0, 0, 1));
      tbl.push_back(mk(4'd4, 15,  8, 0,  0,  0, 0, 0, 1));
      tbl.push_back(mk(4'd5, 12, 10, 1,  0,  8, 0, 0, 1));
      tbl.push_back(mk(4'd6, 12, 10, 0,  0,  7, 0, 0, 1));
      tbl.push_back(mk(4'd7, 12, 10, 0,  0, 14, 0, 0, 1));
      tbl.push_back(mk(4'd8, 12, 10, 0,  0,  1, 0, 0, 1));
      tbl.push_back(mk(4'd9, 12, 10, 0,  0,  6, 0, 0, 1));
      tbl.push_back(mk(4'd10, 12, 10, 0, 0,  9, 0, 0, 1));
      tbl.push_back(mk(4'd11, 12,  5, 0, 0,  3, 0, 0, 1));
      tbl.push_back(mk(4'd12,  7,  7, 1, 0,  0, 0, 0, 1));
      tbl.push_back(mk(4'd15,  9,  3, 0, 0,  0, 0, 0, 1));
      foreach (tbl[i]) run_op(0, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].exp, "table");

      // Back-pressure: result held for three cycles, then a new op rides the out_ready edge.
      @(negedge clk);
      t_ordy = 1'b0;
      t_op = 4'd0; t_a = 5; t_b = 5; t_cin = 1'b1; t_iv[0] = 1'b1;
      @(negedge clk);
      t_iv[0] = 1'b0; t_a = 0; t_b = 0;
      for (int i = 0; i < 3; i++) begin
         check("bp out_valid held", 32'(o_ov[0]), 32'd1);
         check("bp result_lo held", lo_of(0), 32'd11);
         check("bp carry held", 32'(o_cout[0]), 32'd0);
         check("bp in_ready low", 32'(o_irdy[0]), 32'd0);
         @(negedge clk);
      end
      t_ordy = 1'b1;
      t_op = 4'd1; t_a = 6; t_b = 3; t_cin = 1'b1; t_iv[0] = 1'b1;
      #1 check("bp in_ready with out_ready", 32'(o_irdy[0]), 32'd1);
      @(negedge clk);
      t_iv[0] = 1'b0;
      check("bp next op valid", 32'(o_ov[0]), 32'd1);
      check("bp next op result", lo_of(0), 32'd2);
      check("bp next op borrow", 32'(o_cout[0]), 32'd0);

      // Reset during a divide drops it immediately.
      t_op = 4'd3; t_a = 13; t_b = 3; t_cin = 1'b0; t_iv[0] = 1'b1;
      @(negedge clk);
      t_iv[0] = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2 check("div in progress before reset", 32'(o_busy[0]), 32'd1);
      rst = 1'b1;
      #1;
      check("mid-div reset out_valid", 32'(o_ov[0]), 32'd0);
      check("mid-div reset busy", 32'(o_busy[0]), 32'd0);
      check("mid-div reset in_ready", 32'(o_irdy[0]), 32'd0);
      check("mid-div reset result_lo", lo_of(0), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      run_op(0, 4'd0, 10, 10, 1'b1, model(4'd0, 10, 10, 1'b1, 4), "add after reset");

      run_op(1, 4'd2, 32'hFF, 32'hFF, 1'b0, model(4'd2, 32'hFF, 32'hFF, 1'b0, 8), "mul8 max");
      run_op(2, 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0,
             model(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32), "mul32 max");
      run_op(2, 4'd3, 32'hFFFF_FFFF, 32'd7, 1'b0, model(4'd3, 32'hFFFF_FFFF, 32'd7, 1'b0, 32), "div32");

      for (int i = 0; i < 200; i++) begin
         op = 4'($urandom_range(0, 15)); ra = $urandom; rb = $urandom; rc = 1'($urandom);
         run_op(0, op, ra, rb, rc, model(op, ra, rb, rc, 4), "rand4");
      end
      for (int k = 1; k < 3; k++) begin
         for (int i = 0; i < 40; i++) begin
            if (i % 3 == 0) op = 4'($urandom_range(0, 15));
            else            op = (i % 3 == 1) ? 4'd2 : 4'd3;
            ra = $urandom; rb = (i % 10 == 5) ? 32'd0 : $urandom; rc = 1'($urandom);
            if (k == 1 && i % 4 == 2) rb = rb & 32'h0F;
            run_op(k, op, ra, rb, rc, model(op, ra, rb, rc, width_of(k)), "rand_wide");
         end
      end

      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
